// File: rtl/sseg_pattern_animator_pkg.sv
// Shared types and segment encodings for the seven-segment pattern animator.
// Segment constants are bit masks into {dp,g,f,e,d,c,b,a}; the display is active-low.
package sseg_pkg;

    typedef enum logic [1:0] {
        MODE_HEART = 2'd0,
        MODE_SNAKE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    localparam logic [7:0] SEG_A   = 8'h01;
    localparam logic [7:0] SEG_B   = 8'h02;
    localparam logic [7:0] SEG_C   = 8'h04;
    localparam logic [7:0] SEG_D   = 8'h08;
    localparam logic [7:0] SEG_E   = 8'h10;
    localparam logic [7:0] SEG_F   = 8'h20;
    localparam logic [7:0] SEG_G   = 8'h40;
    localparam logic [7:0] SEG_DP  = 8'h80;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Number of animation steps before the step counter wraps, per mode.
    function automatic int mode_period(input mode_e m, input int n_digits);
        case (m)
            MODE_HEART: return (n_digits > 2) ? n_digits - 2 : 1;
            MODE_SNAKE: return 2 * n_digits + 4;
            MODE_BLINK: return 2;
            default:    return 1;
        endcase
    endfunction

    // Active-low drive word with only the given segments lit.
    function automatic logic [7:0] seg_lit(input logic [7:0] bits);
        return SEG_OFF & ~bits;
    endfunction

endpackage

// File: rtl/sseg_pattern_animator_scan_mux.sv
// Time-multiplexed digit scanner: free-running refresh counter whose top bits pick
// the active digit; an/seg are registered from the per-digit pattern array.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SSEG_TICK = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          pat [N_DIGITS],
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          seg
);

    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [SSEG_TICK-1:0] refresh_q;
    logic [SEL_W-1:0]     sel;

    assign sel = refresh_q[SSEG_TICK-1 -: SEL_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
            an        <= '1;
            seg       <= SEG_OFF;
        end else begin
            refresh_q <= refresh_q + SSEG_TICK'(1);
            // Select codes past the last digit (non power-of-two N) blank the display.
            if (int'(sel) < N_DIGITS) begin
                an  <= ~(N_DIGITS'(1) << sel);
                seg <= pat[sel];
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: rtl/sseg_pattern_animator.sv
// N-digit seven-segment animator: prescaler, step counter, mode tracking and a
// combinational per-digit pattern generator feeding the scan multiplexer.
module sseg_pattern_animator
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SSEG_TICK = 16,
    parameter int ANIM_TICK = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic [1:0]          speed,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          seg,
    output logic                step_tick
);

    localparam int HALF   = N_DIGITS / 2;
    localparam int STEP_W = $clog2(2 * N_DIGITS + 4);

    logic [ANIM_TICK-1:0] presc_q;
    logic [ANIM_TICK-1:0] presc_mask;
    logic [STEP_W-1:0]    step_q;
    logic [STEP_W-1:0]    step_next;
    logic [STEP_W-1:0]    step_last;
    mode_e                mode_q;
    mode_e                mode_in;
    logic                 mode_change;
    logic                 tick_raw;
    logic                 reverse;
    logic [7:0]           pat [N_DIGITS];
    int                   step_i;
    int                   hb_k;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_in != mode_q);
    assign presc_mask  = {ANIM_TICK{1'b1}} >> speed;
    assign tick_raw    = en && ((presc_q & presc_mask) == presc_mask);
    // A tick coinciding with a mode switch is swallowed so the new pattern starts at step 0.
    assign step_tick   = tick_raw && !mode_change;
    assign reverse     = dir && (mode_q == MODE_SNAKE);
    assign step_last   = STEP_W'(mode_period(mode_q, N_DIGITS) - 1);

    always_comb begin
        step_next = '0;
        if (reverse) begin
            step_next = (step_q == '0) ? step_last : step_q - STEP_W'(1);
        end else begin
            step_next = (step_q >= step_last) ? '0 : step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            step_q  <= '0;
            mode_q  <= MODE_HEART;
        end else begin
            mode_q <= mode_in;
            if (mode_change) begin
                presc_q <= '0;
                step_q  <= '0;
            end else if (en) begin
                presc_q <= presc_q + ANIM_TICK'(1);
                if (tick_raw) begin
                    step_q <= step_next;
                end
            end
        end
    end

    // Heartbeat folds the step into a ping-pong offset k from the display centre.
    always_comb begin
        step_i = int'(step_q);
        hb_k   = (step_i < HALF) ? step_i : N_DIGITS - 2 - step_i;
        for (int d = 0; d < N_DIGITS; d++) begin
            pat[d] = SEG_OFF;
            case (mode_q)
                MODE_HEART: begin
                    if (d == HALF + hb_k) begin
                        pat[d] = seg_lit(SEG_F | SEG_E);
                    end else if (d == HALF - 1 - hb_k) begin
                        pat[d] = seg_lit(SEG_B | SEG_C);
                    end
                end
                MODE_SNAKE: begin
                    // Perimeter walk: top row leftward-to-right, right side, bottom row, left side.
                    if (step_i < N_DIGITS) begin
                        if (d == N_DIGITS - 1 - step_i) pat[d] = seg_lit(SEG_A);
                    end else if (step_i == N_DIGITS) begin
                        if (d == 0) pat[d] = seg_lit(SEG_B);
                    end else if (step_i == N_DIGITS + 1) begin
                        if (d == 0) pat[d] = seg_lit(SEG_C);
                    end else if (step_i < 2 * N_DIGITS + 2) begin
                        if (d == step_i - N_DIGITS - 2) pat[d] = seg_lit(SEG_D);
                    end else if (step_i == 2 * N_DIGITS + 2) begin
                        if (d == N_DIGITS - 1) pat[d] = seg_lit(SEG_E);
                    end else begin
                        if (d == N_DIGITS - 1) pat[d] = seg_lit(SEG_F);
                    end
                end
                MODE_BLINK: begin
                    if (step_q == '0) pat[d] = seg_lit(SEG_DP);
                end
                default: begin
                    pat[d] = SEG_OFF;
                end
            endcase
        end
    end

    sseg_scan_mux #(
        .N_DIGITS (N_DIGITS),
        .SSEG_TICK(SSEG_TICK)
    ) u_scan (
        .clk  (clk),
        .reset(reset),
        .pat  (pat),
        .an   (an),
        .seg  (seg)
    );

endmodule
